bbox_packet_tx: RTL and testbench

Serializes each face bounding box into a fixed 12-byte packet and feeds it one byte at a time to the UART byte transmitter, for return to the host. It sits downstream of the bounding-box finder and upstream of the UART TX byte engine, the return path of the pixel link. One box is buffered while a packet is in flight. Overflow policy is newest-wins, with a saturating drop counter.

---
 rtl/bbox_packet_tx.sv | 129 ++++++++++++
 tb/tb_bbox_packet_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_packet_tx.sv
// bbox_packet_tx: serializes each bounding box into a 12-byte packet for the UART TX byte engine
// One box waits in a pending slot during a packet; overflow keeps the newest box and counts drops.
module bbox_packet_tx (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic [10:0] x_min,
    input  logic [10:0] x_max,
    input  logic [10:0] y_min,
    input  logic [10:0] y_max,
    input  logic        pi_flag,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_flag,
    output logic        busy,
    output logic [7:0]  drop_cnt
);
    localparam logic [7:0] HDR0 = 8'hAA;
    localparam logic [7:0] HDR1 = 8'h55;
    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
    state_t      state_q, state_d;
    logic [43:0] box_in, src, act_q, act_d, pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d, sticky_q, sticky_d, tx_flag_q, tx_flag_d;
    logic [5:0]  seq_q, seq_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  status_q, status_d, tx_data_q, tx_data_d, drop_cnt_q, drop_cnt_d, csum;
    logic [7:0]  pkt [12];

    assign box_in   = {x_min, x_max, y_min, y_max};
    assign src      = pend_vld_q ? pend_q : act_q;
    assign tx_data  = tx_data_q;
    assign tx_flag  = tx_flag_q;
    assign busy     = state_q != IDLE;
    assign drop_cnt = drop_cnt_q;

    // The active box is frozen from LOAD to packet end, so bytes decode straight from it
    always_comb begin
        pkt[0] = HDR0;
        pkt[1] = HDR1;
        pkt[2] = status_q;
        csum   = status_q;
        for (int i = 0; i < 4; i++) begin
            pkt[3 + 2*i] = {5'b0, act_q[43 - 11*i -: 3]};
            pkt[4 + 2*i] = act_q[40 - 11*i -: 8];
            csum = csum ^ {5'b0, act_q[43 - 11*i -: 3]} ^ act_q[40 - 11*i -: 8];
        end
        pkt[11] = csum;
    end

    always_comb begin
        state_d    = state_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sticky_d   = sticky_q;
        seq_d      = seq_q;
        idx_d      = idx_q;
        status_d   = status_q;
        tx_data_d  = tx_data_q;
        tx_flag_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (state_q == LOAD && pend_vld_q) begin
            act_d      = pend_q;
            pend_d     = pi_flag ? box_in : pend_q;
            pend_vld_d = pi_flag;
        end else if (state_q != IDLE && pi_flag) begin
            pend_d     = box_in;
            pend_vld_d = 1'b1;
            if (pend_vld_q) begin
                drop_cnt_d = drop_cnt_q + {7'b0, drop_cnt_q != 8'hFF};
                sticky_d   = 1'b1;
            end
        end
        case (state_q)
            IDLE: if (pi_flag) begin
                act_d   = box_in;
                state_d = LOAD;
            end
            LOAD: begin
                status_d  = {seq_q, sticky_q, src[43:33] <= src[32:22] && src[21:11] <= src[10:0]};
                sticky_d  = 1'b0;
                seq_d     = seq_q + 6'd1;
                idx_d     = 4'd0;
                tx_data_d = HDR0;
                tx_flag_d = 1'b1;
                state_d   = SEND;
            end
            SEND: state_d = WAIT;
            WAIT: if (tx_done) begin
                if (idx_q != 4'd11) begin
                    idx_d     = idx_q + 4'd1;
                    tx_data_d = pkt[idx_q + 4'd1];
                    tx_flag_d = 1'b1;
                    state_d   = SEND;
                end else begin
                    state_d = (pi_flag || pend_vld_q) ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sticky_q   <= 1'b0;
            seq_q      <= '0;
            idx_q      <= '0;
            status_q   <= '0;
            tx_data_q  <= '0;
            tx_flag_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sticky_q   <= sticky_d;
            seq_q      <= seq_d;
            idx_q      <= idx_d;
            status_q   <= status_d;
            tx_data_q  <= tx_data_d;
            tx_flag_q  <= tx_flag_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
endmodule

// File: tb/tb_bbox_packet_tx.sv
// tb_bbox_packet_tx: directed and randomized packet checks against a byte-level packet model
module tb_bbox_packet_tx;
    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] x_min = '0, x_max = '0, y_min = '0, y_max = '0;
    logic        pi_flag = 1'b0, tx_done = 1'b0;
    logic [7:0]  tx_data, drop_cnt;
    logic        tx_flag, busy;
    int          vecs = 0, errs = 0;
    int          seq_m = 0, drops_m = 0;
    bit          sticky_m = 1'b0;

    always #5 sclk = ~sclk;

    bbox_packet_tx dut (
        .sclk(sclk), .rst_n(rst_n),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .pi_flag(pi_flag), .tx_done(tx_done),
        .tx_data(tx_data), .tx_flag(tx_flag), .busy(busy), .drop_cnt(drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet as the host sees it: header, status, hi/lo coordinate pairs, XOR checksum
    function automatic logic [95:0] model_pkt(input logic [43:0] b, input int sq, input bit dr);
        int          c [4];
        logic [7:0]  by [12];
        logic [95:0] r;
        for (int i = 0; i < 4; i++) c[i] = int'(b[43 - 11*i -: 11]);
        by[0] = 8'hAA;
        by[1] = 8'h55;
        by[2] = 8'(sq * 4 + (dr ? 2 : 0) + ((c[0] <= c[1] && c[2] <= c[3]) ? 1 : 0));
        for (int i = 0; i < 4; i++) begin
            by[3 + 2*i] = 8'(c[i] / 256);
            by[4 + 2*i] = 8'(c[i] % 256);
        end
        by[11] = 8'h00;
        for (int i = 2; i < 11; i++) by[11] = by[11] ^ by[i];
        r = '0;
        for (int i = 0; i < 12; i++) r[95 - 8*i -: 8] = by[i];
        return r;
    endfunction

    function automatic logic [43:0] rand_box();
        return 44'({$urandom, $urandom});
    endfunction

    task automatic load_box(input logic [43:0] b, output logic [95:0] p);
        p = model_pkt(b, seq_m, sticky_m);
        seq_m = (seq_m + 1) % 64;
        sticky_m = 1'b0;
    endtask

    task automatic drive_box(input logic [43:0] b, input bit pulse);
        {x_min, x_max, y_min, y_max} = b;
        pi_flag = pulse;
    endtask

    task automatic scramble();
        drive_box(rand_box(), 1'b0);
    endtask

    task automatic pulse_box(input logic [43:0] b);
        drive_box(b, 1'b1);
        @(negedge sclk);
        scramble();
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp, input int lat, input bit spur);
        int w = 0;
        while (tx_flag !== 1'b1 && w < 60) begin
            @(negedge sclk);
            w++;
        end
        check({tag, "_lat"}, 32'(w), 32'(lat));
        check({tag, "_data"}, 32'({busy, tx_data}), 32'({1'b1, exp}));
        if (spur) tx_done = 1'b1;
        @(negedge sclk);
        tx_done = 1'b0;
        check({tag, "_pulse"}, 32'({tx_flag, tx_data}), 32'({1'b0, exp}));
    endtask

    task automatic ack(input int gap);
        repeat (gap) @(negedge sclk);
        tx_done = 1'b1;
        @(negedge sclk);
        tx_done = 1'b0;
    endtask

    task automatic send_pkt(input string tag, input logic [95:0] p, input int first, input int last,
                            input int lat0, input int gap, input int spur_idx, input bit scr);
        for (int i = first; i <= last; i++) begin
            expect_byte($sformatf("%s_b%0d", tag, i), p[95 - 8*i -: 8], (i == first) ? lat0 : 0, i == spur_idx);
            if (scr) scramble();
            ack(gap);
        end
    endtask

    initial begin
        logic [43:0] b, b2, b3;
        logic [95:0] p, p2, p3;
        int          w;
        scramble();
        repeat (3) @(negedge sclk);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_flag_busy", 32'({tx_flag, busy}), 32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        rst_n = 1'b1;
        @(negedge sclk);
        tx_done = 1'b1;
        repeat (2) @(negedge sclk);
        tx_done = 1'b0;
        @(negedge sclk);
        check("idle_spurious_done", 32'({tx_flag, busy}), 32'h0);

        b = {11'd100, 11'd300, 11'd50, 11'd200};
        pulse_box(b);
        check("norm_t1", 32'({busy, tx_flag}), 32'h2);
        load_box(b, p);
        send_pkt("norm", 96'hAA55_0100_6401_2C00_3200_C8B2, 0, 11, 1, 9, -1, 1);
        check("norm_busy_fall", 32'(busy), 32'h0);

        for (int k = 0; k < 4; k++) begin
            b = rand_box();
            pulse_box(b);
            load_box(b, p);
            send_pkt($sformatf("rnd%0d", k), p, 0, 11, 1, $urandom_range(0, 4), $urandom_range(0, 11), 1);
            check("rnd_busy_fall", 32'(busy), 32'h0);
        end

        b = rand_box(); b2 = rand_box(); b3 = rand_box();
        pulse_box(b);
        load_box(b, p);
        expect_byte("ovf_a_b0", p[95:88], 1, 0);
        pulse_box(b2);
        pulse_box(b3);
        drops_m++;
        sticky_m = 1'b1;
        check("ovf_drop_cnt", 32'(drop_cnt), 32'(drops_m));
        ack(0);
        send_pkt("ovf_a", p, 1, 11, 0, 1, -1, 1);
        check("ovf_pending_busy", 32'(busy), 32'h1);
        load_box(b3, p3);
        send_pkt("ovf_c", p3, 0, 11, 1, 0, -1, 0);
        check("ovf_c_busy_fall", 32'(busy), 32'h0);
        b = rand_box();
        pulse_box(b);
        load_box(b, p);
        send_pkt("ovf_d", p, 0, 11, 1, 0, -1, 0);

        b = rand_box();
        pulse_box(b);
        load_box(b, p);
        send_pkt("b2b_a", p, 0, 10, 1, 0, -1, 1);
        expect_byte("b2b_a_b11", p[7:0], 0, 0);
        b2 = rand_box();
        drive_box(b2, 1'b1);
        tx_done = 1'b1;
        @(negedge sclk);
        tx_done = 1'b0;
        scramble();
        check("b2b_no_idle", 32'(busy), 32'h1);
        load_box(b2, p2);
        send_pkt("b2b_e", p2, 0, 11, 1, 0, -1, 0);
        check("b2b_busy_fall", 32'(busy), 32'h0);

        b = rand_box();
        pulse_box(b);
        load_box(b, p);
        expect_byte("sat_g_b0", p[95:88], 1, 0);
        for (int i = 0; i < 301; i++) begin
            b2 = rand_box();
            drive_box(b2, 1'b1);
            @(negedge sclk);
        end
        scramble();
        drops_m = (drops_m + 300 > 255) ? 255 : drops_m + 300;
        sticky_m = 1'b1;
        check("sat_drop_cnt", 32'(drop_cnt), 32'(drops_m));
        ack(2);
        send_pkt("sat_g", p, 1, 11, 0, 0, -1, 0);
        check("sat_pending_busy", 32'(busy), 32'h1);
        load_box(b2, p2);
        send_pkt("sat_h", p2, 0, 11, 1, 0, -1, 0);
        check("sat_drop_hold", 32'(drop_cnt), 32'(drops_m));

        b = rand_box();
        pulse_box(b);
        load_box(b, p);
        send_pkt("rst_a", p, 0, 4, 1, 0, -1, 0);
        w = 0;
        while (tx_flag !== 1'b1 && w < 60) begin
            @(negedge sclk);
            w++;
        end
        check("rst_a_b5_lat", 32'(w), 32'h0);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'({tx_flag, busy, tx_data, drop_cnt}), 32'h0);
        seq_m = 0;
        sticky_m = 1'b0;
        drops_m = 0;
        @(negedge sclk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge sclk);
            check("rst_quiet", 32'({tx_flag, busy}), 32'h0);
        end
        b = {11'd1023, 11'd0, 11'd755, 11'd0};
        pulse_box(b);
        load_box(b, p);
        send_pkt("empty", 96'hAA55_0003_FF00_0002_F300_000D, 0, 11, 1, 0, -1, 1);
        check("empty_busy_fall", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
